// File: rtl/acc_pkg.sv
// Shared widths, tile length and state encoding for the accumulator tile arbiter.
package acc_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int NUM_REQ        = 4;
   localparam int REQ_ID_WIDTH   = 2;
   // Also sets the accumulator's NOP count, so tile length has one source.
   localparam int TILE_LEN       = 4;
   localparam int BEAT_CNT_WIDTH = 2;
   localparam int TAG_DEPTH      = 8;
   localparam int TAG_WIDTH      = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

endpackage

// File: rtl/acc_tag_fifo.sv
// Tag FIFO holding the lane ID of each granted tile until its result returns.
module acc_tag_fifo
   import acc_pkg::*;
#(
   parameter int IdWidth   = REQ_ID_WIDTH,
   parameter int Depth     = TAG_DEPTH,
   parameter int AddrWidth = TAG_WIDTH
) (
   input  logic               clk,
   input  logic               aclr,
   input  logic               sclr,
   input  logic               Push,
   input  logic [IdWidth-1:0] PushId,
   input  logic               Pop,
   output logic               Full,
   output logic               Empty,
   output logic [IdWidth-1:0] Head
);

   logic [IdWidth-1:0]   mem_q [Depth];
   logic [AddrWidth-1:0] wr_q, wr_d;
   logic [AddrWidth-1:0] rd_q, rd_d;
   logic [AddrWidth:0]   cnt_q, cnt_d;
   logic                 do_push, do_pop;

   assign Full  = (cnt_q == (AddrWidth+1)'(Depth));
   assign Empty = (cnt_q == '0);
   assign Head  = mem_q[rd_q];

   always_comb begin
      do_push = Push & ~Full;
      do_pop  = Pop & ~Empty;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (sclr) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !sclr) mem_q[wr_q] <= PushId;
   end

endmodule

// File: rtl/acc_tile_arbiter.sv
// Grants one lane per tile to a shared accumulator and tags results by lane.
// Define ACC_TILE_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module acc_tile_arbiter
   import acc_pkg::*;
#(
   parameter int DataWidth    = DATA_WIDTH,
   parameter int NumReq       = NUM_REQ,
   parameter int ReqIdWidth   = REQ_ID_WIDTH,
   parameter int TileLen      = TILE_LEN,
   parameter int BeatCntWidth = BEAT_CNT_WIDTH,
   parameter int TagDepth     = TAG_DEPTH,
   parameter int TagWidth     = TAG_WIDTH
) (
   input  logic                        clk,
   input  logic                        aclr,
   input  logic                        sclr,
   input  logic [NumReq-1:0]           ReqValid,
   input  logic [NumReq*DataWidth-1:0] ReqData,
   output logic [NumReq-1:0]           ReqRdy,
   output logic                        AccInValid,
   output logic [DataWidth-1:0]        AccInData,
   input  logic                        AccInRdy,
   input  logic                        AccOutValid,
   input  logic [DataWidth-1:0]        AccOutData,
   output logic                        AccOutRdy,
   output logic                        ResValid,
   output logic [DataWidth-1:0]        ResData,
   output logic [ReqIdWidth-1:0]       ResId,
   input  logic                        ResRdy,
   output logic                        Busy,
   output logic                        ErrOrphan
);

   state_e                  state_q, state_d;
   logic [ReqIdWidth-1:0]   grant_q, grant_d;
   logic [BeatCntWidth-1:0] beat_q, beat_d;
   logic                    err_q, err_d;
   logic                    sel_valid;
   logic [ReqIdWidth-1:0]   sel_id;
   logic                    tag_push, tag_pop;
   logic                    tag_full, tag_empty;
   logic [ReqIdWidth-1:0]   tag_head;

`ifdef ACC_TILE_ARB_FIXED_PRIO_EN
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (ReqValid[i]) begin
            sel_valid = 1'b1;
            sel_id    = ReqIdWidth'(i);
         end
      end
   end
`else
   logic [ReqIdWidth-1:0] last_q, last_d;

   // Descending scan so the lane nearest after last_q is written last.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = '0;
      for (int i = NumReq; i >= 1; i--) begin
         if (ReqValid[(int'(last_q) + i) % NumReq]) begin
            sel_valid = 1'b1;
            sel_id    = ReqIdWidth'((int'(last_q) + i) % NumReq);
         end
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      beat_d     = beat_q;
      err_d      = err_q | (AccOutValid & tag_empty);
      tag_push   = 1'b0;
      ReqRdy     = '0;
      AccInValid = 1'b0;
      AccInData  = ReqData[grant_q*DataWidth +: DataWidth];
`ifndef ACC_TILE_ARB_FIXED_PRIO_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (sel_valid && !tag_full) begin
               grant_d  = sel_id;
               tag_push = 1'b1;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            AccInValid       = ReqValid[grant_q];
            ReqRdy[grant_q]  = AccInRdy;
            if (AccInValid && AccInRdy) begin
               if (beat_q == BeatCntWidth'(TileLen - 1)) begin
                  beat_d  = '0;
                  state_d = IDLE;
`ifndef ACC_TILE_ARB_FIXED_PRIO_EN
                  last_d  = grant_q;
`endif
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_q <= IDLE;
         grant_q <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else if (sclr) begin
         state_q <= IDLE;
         grant_q <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

`ifndef ACC_TILE_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr)      last_q <= ReqIdWidth'(NumReq - 1);
      else if (sclr) last_q <= ReqIdWidth'(NumReq - 1);
      else           last_q <= last_d;
   end
`endif

   assign ResValid  = AccOutValid & ~tag_empty;
   assign ResData   = AccOutData;
   assign ResId     = tag_head;
   assign AccOutRdy = ResRdy & ~tag_empty;
   assign tag_pop   = ResValid & ResRdy;
   assign Busy      = (state_q == STREAM);
   assign ErrOrphan = err_q;

   acc_tag_fifo #(
      .IdWidth   (ReqIdWidth),
      .Depth     (TagDepth),
      .AddrWidth (TagWidth)
   ) u_tag_fifo (
      .clk    (clk),
      .aclr   (aclr),
      .sclr   (sclr),
      .Push   (tag_push),
      .PushId (grant_d),
      .Pop    (tag_pop),
      .Full   (tag_full),
      .Empty  (tag_empty),
      .Head   (tag_head)
   );

endmodule

// File: tb/tb_acc_tile_arbiter.sv
// Directed bench for acc_tile_arbiter; expectations follow the macro build.
module tb_acc_tile_arbiter;

   logic         clk = 1'b0;
   logic         aclr;
   logic         sclr;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_rdy;
   logic         acc_in_valid;
   logic [31:0]  acc_in_data;
   logic         acc_in_rdy;
   logic         acc_out_valid;
   logic [31:0]  acc_out_data;
   logic         acc_out_rdy;
   logic         res_valid;
   logic [31:0]  res_data;
   logic [1:0]   res_id;
   logic         res_rdy;
   logic         busy;
   logic         err_orphan;

   int tests = 0;
   int fails = 0;

   logic [31:0] fp_beats [4] = '{32'h3F80_0000, 32'h4000_0000,
                                 32'h4040_0000, 32'h4080_0000};
`ifdef ACC_TILE_ARB_FIXED_PRIO_EN
   int exp_t2 [4] = '{1, 1, 1, 1};
   int exp_t3 [2] = '{0, 0};
`else
   int exp_t2 [4] = '{1, 3, 1, 3};
   int exp_t3 [2] = '{0, 2};
`endif

   always #5 clk = ~clk;

   acc_tile_arbiter dut (
      .clk         (clk),
      .aclr        (aclr),
      .sclr        (sclr),
      .ReqValid    (req_valid),
      .ReqData     (req_data),
      .ReqRdy      (req_rdy),
      .AccInValid  (acc_in_valid),
      .AccInData   (acc_in_data),
      .AccInRdy    (acc_in_rdy),
      .AccOutValid (acc_out_valid),
      .AccOutData  (acc_out_data),
      .AccOutRdy   (acc_out_rdy),
      .ResValid    (res_valid),
      .ResData     (res_data),
      .ResId       (res_id),
      .ResRdy      (res_rdy),
      .Busy        (busy),
      .ErrOrphan   (err_orphan)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      aclr          = 1'b1;
      sclr          = 1'b0;
      req_valid     = '0;
      req_data      = '0;
      acc_in_rdy    = 1'b0;
      acc_out_valid = 1'b0;
      acc_out_data  = '0;
      res_rdy       = 1'b1;
      #12;
      chk("rst_reqrdy", 32'(req_rdy), 0);
      chk("rst_accinvalid", 32'(acc_in_valid), 0);
      chk("rst_resvalid", 32'(res_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err_orphan), 0);
      chk("rst_accoutrdy", 32'(acc_out_rdy), 0);
      aclr = 1'b0;
      tick();

      // single lane 0 tile of 1.0..4.0
      req_valid  = 4'b0001;
      acc_in_rdy = 1'b1;
      res_rdy    = 1'b0;
      req_data[31:0] = fp_beats[0];
      #1;
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_idle_rdy", 32'(req_rdy), 0);
      tick();
      for (int b = 0; b < 4; b++) begin
         req_data[31:0] = fp_beats[b];
         #1;
         chk("t1_valid", 32'(acc_in_valid), 1);
         chk("t1_data", acc_in_data, fp_beats[b]);
         chk("t1_reqrdy", 32'(req_rdy), 32'h1);
         tick();
      end
      req_valid = '0;
      #1;
      chk("t1_done_busy", 32'(busy), 0);
      acc_out_valid = 1'b1;
      acc_out_data  = 32'h4120_0000;
      res_rdy       = 1'b1;
      #1;
      chk("t1_resvalid", 32'(res_valid), 1);
      chk("t1_resdata", res_data, 32'h4120_0000);
      chk("t1_resid", 32'(res_id), 0);
      chk("t1_accoutrdy", 32'(acc_out_rdy), 1);
      tick();
      acc_out_valid = 1'b0;
      #1;
      chk("t1_empty", 32'(acc_out_rdy), 0);

      // lanes 1 and 3 continuously valid
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA000_0000 + i;
      req_valid = 4'b1010;
      res_rdy   = 1'b0;
      for (int t = 0; t < 4; t++) begin
         #1;
         chk("t2_idle_busy", 32'(busy), 0);
         tick();
         for (int b = 0; b < 4; b++) begin
            chk("t2_reqrdy", 32'(req_rdy), 32'(1) << exp_t2[t]);
            chk("t2_data", acc_in_data, 32'hA000_0000 + exp_t2[t]);
            tick();
         end
      end
      req_valid     = '0;
      acc_out_valid = 1'b1;
      res_rdy       = 1'b1;
      for (int t = 0; t < 4; t++) begin
         #1;
         chk("t2_resid", 32'(res_id), exp_t2[t]);
         tick();
      end
      acc_out_valid = 1'b0;
      res_rdy       = 1'b0;

      // lanes 0 and 2 continuously valid
      req_valid = 4'b0101;
      for (int t = 0; t < 2; t++) begin
         #1;
         tick();
         for (int b = 0; b < 4; b++) begin
            chk("t3_reqrdy", 32'(req_rdy), 32'(1) << exp_t3[t]);
            tick();
         end
      end
      req_valid     = '0;
      acc_out_valid = 1'b1;
      res_rdy       = 1'b1;
      for (int t = 0; t < 2; t++) begin
         #1;
         chk("t3_resid", 32'(res_id), exp_t3[t]);
         tick();
      end
      acc_out_valid = 1'b0;
      res_rdy       = 1'b0;

      // fill the tag FIFO with 8 tiles, 9th grant must stall
      req_valid = 4'b0001;
      #1;
      for (int t = 0; t < 8; t++) begin
         tick();
         repeat (4) tick();
      end
      chk("t4_full_idle", 32'(busy), 0);
      tick();
      chk("t4_full_busy", 32'(busy), 0);
      chk("t4_full_rdy", 32'(req_rdy), 0);
      tick();
      chk("t4_full_busy2", 32'(busy), 0);
      acc_out_valid = 1'b1;
      res_rdy       = 1'b1;
      #1;
      chk("t4_pop_valid", 32'(res_valid), 1);
      tick();
      acc_out_valid = 1'b0;
      res_rdy       = 1'b0;
      #1;
      chk("t4_pop_busy", 32'(busy), 0);
      tick();
      chk("t4_regrant_busy", 32'(busy), 1);
      chk("t4_regrant_rdy", 32'(req_rdy), 32'h1);
      repeat (4) tick();
      req_valid     = '0;
      acc_out_valid = 1'b1;
      res_rdy       = 1'b1;
      for (int t = 0; t < 8; t++) begin
         #1;
         chk("t4_drain_id", 32'(res_id), 0);
         tick();
      end
      acc_out_valid = 1'b0;
      #1;
      chk("t4_drained", 32'(acc_out_rdy), 0);
      res_rdy = 1'b0;

      // lane 2 bubbles on alternate cycles, lane 1 pending
      req_valid = 4'b0100;
      #1;
      tick();
      for (int c = 0; c < 7; c++) begin
         req_valid = (c % 2 == 0) ? 4'b0110 : 4'b0010;
         #1;
         chk("t5_busy", 32'(busy), 1);
         chk("t5_valid", 32'(acc_in_valid), (c % 2 == 0) ? 1 : 0);
         chk("t5_reqrdy", 32'(req_rdy), 32'h4);
         tick();
      end
      req_valid = '0;
      #1;
      chk("t5_done_busy", 32'(busy), 0);
      acc_out_valid = 1'b1;
      res_rdy       = 1'b1;
      #1;
      chk("t5_resid", 32'(res_id), 2);
      tick();
      acc_out_valid = 1'b0;

      // sclr mid-tile, then orphan result
      req_valid = 4'b0001;
      #1;
      tick();
      repeat (2) tick();
      sclr = 1'b1;
      tick();
      sclr      = 1'b0;
      req_valid = '0;
      #1;
      chk("t6_busy", 32'(busy), 0);
      chk("t6_reqrdy", 32'(req_rdy), 0);
      chk("t6_empty", 32'(acc_out_rdy), 0);
      acc_out_valid = 1'b1;
      #1;
      chk("t6_orphan_valid", 32'(res_valid), 0);
      chk("t6_orphan_rdy", 32'(acc_out_rdy), 0);
      tick();
      acc_out_valid = 1'b0;
      #1;
      chk("t6_err", 32'(err_orphan), 1);
      tick();
      chk("t6_err_sticky", 32'(err_orphan), 1);
      req_valid = 4'b0001;
      #1;
      tick();
      repeat (3) tick();
      chk("t6_beat3_busy", 32'(busy), 1);
      tick();
      req_valid = '0;
      #1;
      chk("t6_tile_len", 32'(busy), 0);
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      #1;
      chk("t6_err_clr", 32'(err_orphan), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/acc_tile_arbiter.md
Name: acc_tile_arbiter

Overview:
- Shares one pipelined FP accumulator among NumReq producer lanes (e.g. MAC lanes).
- Grants one lane for a whole tile of TileLen beats, forwarding the beats unbroken and in order.
- Records the granted lane ID in a tag FIFO, so each accumulated result returning from the accumulator is routed back with its lane ID.
- Sits between the lane outputs and the accumulator's DataIn/DataOut valid/ready ports.

Parameters:
- DataWidth, 32, width of operand and result words
- NumReq, 4, number of requesting lanes
- ReqIdWidth, 2, width of lane ID (ceil log2 NumReq)
- TileLen, 4, beats per tile; must equal the accumulator's per-tile input count
- BeatCntWidth, 2, width of beat counter (ceil log2 TileLen)
- TagDepth, 8, outstanding-tile tag FIFO depth (power of 2)
- TagWidth, 3, log2 TagDepth

Ports:
- clk  in  1  clock
- aclr  in  1  asynchronous active-high reset
- sclr  in  1  synchronous clear; assert together with the accumulator's sclr
- ReqValid  in  NumReq  per-lane beat valid
- ReqData  in  NumReq*DataWidth  per-lane data; lane i occupies bits [i*DataWidth +: DataWidth]
- ReqRdy  out  NumReq  per-lane ready; at most one bit set
- AccInValid  out  1  beat valid to the accumulator
- AccInData  out  DataWidth  beat data to the accumulator
- AccInRdy  in  1  accumulator input ready
- AccOutValid  in  1  accumulated result valid
- AccOutData  in  DataWidth  accumulated result
- AccOutRdy  out  1  result ready to the accumulator
- ResValid  out  1  routed result valid
- ResData  out  DataWidth  routed result
- ResId  out  ReqIdWidth  lane that produced the result
- ResRdy  in  1  consumer ready
- Busy  out  1  high in STREAM
- ErrOrphan  out  1  sticky flag: result arrived with tag FIFO empty

Behaviour:
- Reset (aclr) values:
  - State=IDLE, Grant=0, LastGrant=NumReq-1, BeatCnt=0, tag FIFO empty, ErrOrphan=0.
  - Hence all outputs low/zero: ReqRdy=0, AccInValid=0, ResValid=0, Busy=0.
- sclr has the same effect as aclr, applied synchronously; it takes priority over all other updates. Mid-tile sclr aborts the tile; its tag is discarded.
- IDLE state:
  - ReqRdy=0, AccInValid=0.
  - If any ReqValid and the tag FIFO is not full: select Grant by round-robin, searching from LastGrant+1 with wrap at NumReq.
  - On selection, push Grant into the tag FIFO and go to STREAM.
  - Grant overhead is one cycle; the earliest first beat is in the next cycle.
- STREAM state:
  - AccInValid=ReqValid[Grant], AccInData=lane Grant slice.
  - ReqRdy[Grant]=AccInRdy; all other ReqRdy bits are 0.
  - A beat handshake is AccInValid&AccInRdy; on each handshake BeatCnt increments.
  - On the handshake with BeatCnt==TileLen-1: BeatCnt=0, LastGrant=Grant, go to IDLE.
  - Bubbles (ReqValid low) hold the state. The granted lane is never preempted mid-tile.
- Result path:
  - ResValid=AccOutValid & ~TagEmpty; ResData=AccOutData; ResId=tag FIFO head.
  - AccOutRdy=ResRdy & ~TagEmpty.
  - Pop the tag on ResValid&ResRdy.
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged. A push while full cannot occur because the grant is gated on not-full.
- AccOutValid with tag empty sets ErrOrphan (sticky until aclr/sclr); the result is not acknowledged.
- The tag FIFO wraps its pointers modulo TagDepth; Full and Empty are derived from a TagWidth+1 count.
- Results return in tile-grant order; the accumulator is in-order, so the FIFO head always matches.

Optional Feature:
- Macro ACC_TILE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid lane wins, and LastGrant is unused.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package acc_pkg holds:
  - the state encoding (IDLE=0, STREAM=1);
  - the default widths;
  - the tile-length constant shared with the accumulator's NOP count, so the two cannot diverge.
- One sub-module, acc_tag_fifo: a synchronous FIFO of ReqIdWidth-bit tags, depth TagDepth, with Push/Pop/Full/Empty/Head, aclr and sclr.

Test Plan:
- Single lane 0 streams 4 beats 1.0, 2.0, 3.0, 4.0 with AccInRdy=1 → AccInData sequence in the same order, ReqRdy=4'b0001 during STREAM; returned result 10.0 → ResValid=1, ResId=0.
- Lanes 1 and 3 valid continuously → grants alternate 1,3,1,3; each tile is 4 contiguous beats; ResId order 1,3,1,3.
- With ACC_TILE_ARB_FIXED_PRIO_EN defined, lanes 0 and 2 continuously valid → lane 0 granted every tile, lane 2 starved.
- ResRdy=0 and AccOutValid withheld while 8 tiles are granted → tag FIFO full, 9th grant blocked (Busy=0, ReqRdy=0). One result popped → next grant issues the following cycle.
- Lane 2 valid only on alternate cycles mid-tile → no other lane granted until 4 handshakes complete; BeatCnt returns to 0.
- sclr asserted after 2 beats → state IDLE, tag FIFO empty, ReqRdy=0 next cycle. A later AccOutValid with no outstanding tile → ErrOrphan=1, AccOutRdy=0.
